// File: rtl/video_mode_pkg.sv
// Shared types for the video mode controller: FSM states, mode bundle
// and the mask of fields whose change alters output timing.
package video_mode_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STABLE,
        WAIT_VS,
        MUTE_PRE,
        APPLY,
        MUTE_POST
    } state_e;

    typedef struct packed {
        logic       scandoubler_disable;
        logic       ypbpr;
        logic [1:0] scanlines;
        logic [1:0] rotate;
        logic       blend;
    } mode_cfg_t;

    localparam mode_cfg_t TIMING_MASK = 7'b110_0000;

    function automatic logic timing_differs(mode_cfg_t a, mode_cfg_t b);
        return |((a ^ b) & TIMING_MASK);
    endfunction

endpackage

// File: rtl/video_frame_tick.sv
// One-cycle frame tick from the active VSync edge.
// VIDEO_MODE_CTRL_WATCHDOG_EN adds a synthetic tick after WDT_CYCLES quiet cycles.
module video_frame_tick #(
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned WDT_CYCLES = 1 << 20
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic VSync,
    output logic frame_tick
);

    logic vs_q;
    logic edge_hit;

    assign edge_hit = (VSync == VS_POL) && (vs_q != VS_POL);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vs_q <= ~VS_POL;
        end else begin
            vs_q <= VSync;
        end
    end

`ifdef VIDEO_MODE_CTRL_WATCHDOG_EN
    localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt;
    logic             wdt_hit;

    assign wdt_hit = (wdt_cnt == WDT_LAST);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wdt_cnt    <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= edge_hit | wdt_hit;
            if (edge_hit || wdt_hit) begin
                wdt_cnt <= '0;
            end else begin
                wdt_cnt <= wdt_cnt + 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= edge_hit;
        end
    end
`endif

endmodule

// File: rtl/video_mode_ctrl.sv
// Debounces requested video settings and applies them on a frame boundary,
// blanking around timing changes. Watchdog: VIDEO_MODE_CTRL_WATCHDOG_EN.
module video_mode_ctrl
    import video_mode_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MUTE_FRAMES   = 2,
    parameter bit          VS_POL        = 1'b0,
    parameter int unsigned WDT_CYCLES    = 1 << 20
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       VSync,
    input  logic       req_scandoubler_disable,
    input  logic       req_ypbpr,
    input  logic [1:0] req_scanlines,
    input  logic [1:0] req_rotate,
    input  logic       req_blend,
    output logic       scandoubler_disable,
    output logic       ypbpr,
    output logic       blend,
    output logic [1:0] scanlines,
    output logic [1:0] rotate,
    output logic       mute,
    output logic       busy
);

    localparam int unsigned DEB_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned FRM_W = $clog2(MUTE_FRAMES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(STABLE_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(STABLE_CYCLES);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(MUTE_FRAMES - 1);
    localparam logic [FRM_W-1:0] FRM_MAX  = FRM_W'(MUTE_FRAMES);
    localparam logic [FRM_W-1:0] FRM_ONE  = FRM_W'(1);

    state_e           state;
    state_e           state_d;
    mode_cfg_t        req;
    mode_cfg_t        req_q;
    mode_cfg_t        cfg_q;
    logic [DEB_W-1:0] deb_cnt;
    logic [FRM_W-1:0] frm_cnt;
    logic             from_pre;
    logic             frame_tick;
    logic             req_chg;
    logic             frm_done;

    video_frame_tick #(
        .VS_POL     (VS_POL),
        .WDT_CYCLES (WDT_CYCLES)
    ) u_frame_tick (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .VSync      (VSync),
        .frame_tick (frame_tick)
    );

    assign req      = {req_scandoubler_disable, req_ypbpr,
                       req_scanlines, req_rotate, req_blend};
    assign req_chg  = (req != req_q);
    assign frm_done = frame_tick && (frm_cnt >= FRM_LAST);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (req != cfg_q) state_d = STABLE;
            end
            STABLE: begin
                if (req == cfg_q) begin
                    state_d = IDLE;
                end else if (!req_chg && deb_cnt == DEB_LAST) begin
                    state_d = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (req_chg) begin
                    state_d = STABLE;
                end else if (frame_tick) begin
                    state_d = timing_differs(req, cfg_q) ? MUTE_PRE : APPLY;
                end
            end
            MUTE_PRE: begin
                if (frm_done) state_d = APPLY;
            end
            APPLY: begin
                state_d = from_pre ? MUTE_POST : IDLE;
            end
            MUTE_POST: begin
                if (frm_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        mute = 1'b0;
        unique case (state)
            MUTE_PRE, MUTE_POST: mute = 1'b1;
            APPLY:               mute = from_pre;
            default:             mute = 1'b0;
        endcase
    end

    // The tick that starts MUTE_PRE already counts as the first blanked frame.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            req_q    <= '0;
            cfg_q    <= '0;
            deb_cnt  <= '0;
            frm_cnt  <= '0;
            from_pre <= 1'b0;
        end else begin
            req_q <= req;
            if (state == STABLE && !req_chg) begin
                if (deb_cnt != DEB_MAX) deb_cnt <= deb_cnt + 1'b1;
            end else begin
                deb_cnt <= '0;
            end
            if (state_d != state) begin
                frm_cnt <= (state_d == MUTE_PRE) ? FRM_ONE : '0;
            end else if (frame_tick && frm_cnt != FRM_MAX) begin
                frm_cnt <= frm_cnt + 1'b1;
            end
            if (state_d == APPLY) cfg_q <= req;
            if (state == WAIT_VS && state_d == MUTE_PRE) begin
                from_pre <= 1'b1;
            end else if (state_d == IDLE) begin
                from_pre <= 1'b0;
            end
        end
    end

    assign scandoubler_disable = cfg_q.scandoubler_disable;
    assign ypbpr               = cfg_q.ypbpr;
    assign scanlines           = cfg_q.scanlines;
    assign rotate              = cfg_q.rotate;
    assign blend               = cfg_q.blend;

endmodule

// File: doc/video_mode_ctrl.md
VIDEO_MODE_CTRL -- requirements
Module: video_mode_ctrl

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1024: request-debounce length in clk_sys cycles (min 1).
REQ-002 SHALL have parameter MUTE_FRAMES, default 2: blanked frames before and after a timing change (min 1).
REQ-003 SHALL have parameter VS_POL, default 0: 0 = VSync active-low (frame tick on falling edge), 1 = active-high (rising edge).
REQ-004 SHALL have parameter WDT_CYCLES, default 2^20: watchdog period in cycles; used only with the watchdog macro.
REQ-005 clk_sys  in  1  sole clock, rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 VSync  in  1  core vertical sync, polarity per VS_POL.
REQ-008 req_scandoubler_disable, req_ypbpr  in  1 each  requested timing-class settings.
REQ-009 req_scanlines, req_rotate  in  2 each; req_blend  in  1; these are requested cosmetic settings.
REQ-010 scandoubler_disable, ypbpr, blend  out  1 each  applied settings.
REQ-011 scanlines, rotate  out  2 each  applied settings.
REQ-012 mute  out  1  forces downstream RGB to black when high.
REQ-013 busy  out  1  high whenever state is not IDLE.

Function
REQ-014 SHALL form frame_tick as a one-cycle pulse from registered VSync on the active edge per VS_POL; frame_tick latency SHALL be 1 cycle after the sampled edge.
REQ-015 States SHALL be IDLE, STABLE, WAIT_VS, MUTE_PRE, APPLY, MUTE_POST.
REQ-016 IDLE: if the request vector differs from the applied vector, clear the debounce counter and go to STABLE.
REQ-017 STABLE: count cycles while the request vector is unchanged from the previous cycle; restart from 0 on any change; on reaching STABLE_CYCLES go to WAIT_VS; return to IDLE if the request equals the applied vector.
REQ-018 WAIT_VS: a request change returns to STABLE (counter 0); on frame_tick, go to MUTE_PRE if the timing class differs, else go to APPLY.
REQ-019 MUTE_PRE: assert mute; count frame_ticks; after MUTE_FRAMES ticks go to APPLY.
REQ-020 APPLY: lasts exactly 1 cycle; copy the current request vector into all applied outputs; go to MUTE_POST if it entered from MUTE_PRE, else go to IDLE.
REQ-021 MUTE_POST: keep mute high; after MUTE_FRAMES frame_ticks go to IDLE and deassert mute in the same cycle.
REQ-022 Request changes during MUTE_PRE SHALL be taken as sampled at APPLY; changes during MUTE_POST SHALL be handled from IDLE afterwards, with mute not dropped early.
REQ-023 A cosmetic-only change SHALL never assert mute.
REQ-024 Applied outputs SHALL change only in APPLY, all in the same cycle.
REQ-025 Frame counter SHALL be wide enough for MUTE_FRAMES and saturate, never wrap; debounce counter likewise for STABLE_CYCLES.

Reset
REQ-026 On reset: state IDLE, all applied outputs 0, mute 0, busy 0, counters 0, VSync history register loaded with the inactive level (no tick on the first cycle after reset).
REQ-027 Reset mid-sequence (including during mute) SHALL take effect on the next clock edge, with no residual mute.

Configuration
REQ-028 VIDEO_MODE_CTRL_WATCHDOG_EN defined: a counter SHALL count cycles since the last frame_tick; reaching WDT_CYCLES SHALL inject a synthetic frame_tick and clear the counter, so a stalled core cannot deadlock WAIT_VS or MUTE states.
REQ-029 Macro undefined: no watchdog logic exists; progress SHALL depend solely on VSync edges.

Structure
REQ-030 Shared package video_mode_pkg SHALL hold the state enum, a mode-config struct (5 fields, 7 bits), and the timing-class mask constant.
REQ-031 The VSync edge detector and watchdog SHALL be sub-module video_frame_tick (output frame_tick).

Verification (STABLE_CYCLES=4, MUTE_FRAMES=2, WDT_CYCLES=64)
REQ-032 req_scanlines 00->10 held, VSync toggling -> scanlines=10 one cycle after the first tick following 4 stable cycles; mute stays 0.
REQ-033 req_scandoubler_disable 0->1 -> mute rises at tick 1, output changes after tick 2, mute falls at tick 4; busy high throughout.
REQ-034 req_rotate glitching 01/00 every 3 cycles, then settling -> no output change until 4 stable cycles pass.
REQ-035 Reset asserted during MUTE_PRE -> next cycle: mute=0, busy=0, all outputs 0.
REQ-036 Watchdog on, VSync held constant, req_ypbpr=1 -> ypbpr=1 after synthetic ticks (~128 cycles into the sequence); watchdog off -> stays busy in WAIT_VS indefinitely.
